ip_recv: RTL and testbench

- Receive-side IPv4 parser. It is the counterpart of the IP send path.
- Input: 32-bit AXI-stream IPv4 packets, with the Ethernet header already stripped by the MAC receive logic.
- Function: validates the header, strips the header and options, trims Ethernet padding, and forwards the UDP or TCP payload with per-packet metadata to the udp/tcp receive blocks.
- Invalid packets are consumed and dropped, and a drop reason is reported.

---
 rtl/ip_recv.sv | 196 +++++++++++++++++++
 tb/tb_ip_recv.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_recv.sv
// Receive-side IPv4 parser: validates the header (options included), strips it,
// trims Ethernet padding and forwards the UDP/TCP payload with per-packet metadata.
module ip_recv #(
    parameter bit BCAST_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] local_IP_in,
    input  logic [31:0] axis_tdata_in,
    input  logic        axis_tvalid_in,
    input  logic [3:0]  axis_tkeep_in,
    input  logic        axis_tlast_in,
    output logic        axis_tready_out,
    output logic [31:0] data_out,
    output logic        data_valid_out,
    output logic [3:0]  data_keep_out,
    output logic        data_last_out,
    input  logic        data_ready_in,
    output logic [7:0]  proto_out,
    output logic [31:0] src_ip_out,
    output logic [15:0] payload_length_out,
    output logic        drop_out,
    output logic [2:0]  drop_code_out,
    output logic        short_err_out
);
    // Handshakes: a word moves only on a cycle where valid and ready are both high;
    // a holder of valid keeps data/keep/last stable until it sees ready.
    typedef enum logic [1:0] {HDR, OPT, PAYLOAD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] csum_q, csum_d;
    logic [3:0]  ver_q, ver_d, ihl_q, ihl_d;
    logic [15:0] tl_q, tl_d;
    logic        frag_q, frag_d;
    logic [7:0]  hproto_q, hproto_d;
    logic [31:0] hsrc_q, hsrc_d, dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d, last_q, last_d;
    logic [3:0]  keep_q, keep_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [15:0] plen_q, plen_d;
    logic        drop_q, drop_d, short_q, short_d;
    logic [2:0]  code_q, code_d;

    logic        beat, hdr_beat, final_beat, dst_ok;
    logic [31:0] csum_base, csum_next, dst_cur;
    logic [16:0] fold1, plen_s;
    logic [15:0] fold2;
    logic [3:0]  hdr_last, keep_mask;
    logic [2:0]  eval_code;

    assign axis_tready_out = (state_q == PAYLOAD) ? (!valid_q || data_ready_in) : 1'b1;
    assign beat       = axis_tvalid_in && axis_tready_out;
    assign hdr_beat   = beat && (state_q == HDR || state_q == OPT);
    assign csum_base  = (wcnt_q == 4'd0) ? 32'd0 : csum_q;
    assign csum_next  = csum_base + {16'd0, axis_tdata_in[31:16]} + {16'd0, axis_tdata_in[15:0]};
    assign fold1      = {1'b0, csum_next[15:0]} + {1'b0, csum_next[31:16]};
    assign fold2      = fold1[15:0] + {15'd0, fold1[16]};
    // Header ends at W4 unless options follow; IHL<5 is still evaluated at W4.
    assign hdr_last   = (ihl_q > 4'd5) ? ihl_q - 4'd1 : 4'd4;
    assign final_beat = hdr_beat && (wcnt_q == hdr_last);
    assign dst_cur    = (state_q == HDR) ? axis_tdata_in : dst_q;
    assign dst_ok     = (dst_cur == local_IP_in) || (BCAST_EN && dst_cur == 32'hFFFF_FFFF);
    assign plen_s     = {1'b0, tl_q} - {11'd0, ihl_q, 2'b00};

    always_comb begin
        if (ver_q != 4'd4 || ihl_q < 4'd5)                 eval_code = 3'd1;
        else if (fold2 != 16'hFFFF)                         eval_code = 3'd2;
        else if (!dst_ok)                                   eval_code = 3'd3;
        else if (frag_q)                                    eval_code = 3'd4;
        else if (hproto_q != 8'd6 && hproto_q != 8'd17)     eval_code = 3'd5;
        else if (plen_s[16] || plen_s[15:0] == 16'd0)       eval_code = 3'd6;
        else                                                eval_code = 3'd0;
    end

    always_comb begin
        if (rem_q >= 16'd4)      keep_mask = 4'hF;
        else if (rem_q == 16'd3) keep_mask = 4'hE;
        else if (rem_q == 16'd2) keep_mask = 4'hC;
        else                     keep_mask = 4'h8;
    end

    always_comb begin
        state_d  = state_q;  wcnt_d   = wcnt_q;   csum_d  = csum_q;
        ver_d    = ver_q;    ihl_d    = ihl_q;    tl_d    = tl_q;
        frag_d   = frag_q;   hproto_d = hproto_q; hsrc_d  = hsrc_q;
        dst_d    = dst_q;    rem_d    = rem_q;    data_d  = data_q;
        valid_d  = valid_q;  keep_d   = keep_q;   last_d  = last_q;
        proto_d  = proto_q;  src_d    = src_q;    plen_d  = plen_q;
        code_d   = code_q;   drop_d   = 1'b0;     short_d = 1'b0;
        if (valid_q && data_ready_in) valid_d = 1'b0;

        case (state_q)
            HDR, OPT: begin
                if (hdr_beat) begin
                    wcnt_d = wcnt_q + 4'd1;
                    csum_d = csum_next;
                    case (wcnt_q)
                        4'd0: begin
                            ver_d = axis_tdata_in[31:28];
                            ihl_d = axis_tdata_in[27:24];
                            tl_d  = axis_tdata_in[15:0];
                        end
                        4'd1:    frag_d   = axis_tdata_in[13] || (axis_tdata_in[12:0] != 13'd0);
                        4'd2:    hproto_d = axis_tdata_in[23:16];
                        4'd3:    hsrc_d   = axis_tdata_in;
                        4'd4:    dst_d    = axis_tdata_in;
                        default: ;
                    endcase
                    if (final_beat) begin
                        wcnt_d = 4'd0;
                        if (eval_code != 3'd0) begin
                            drop_d  = 1'b1;
                            code_d  = eval_code;
                            state_d = axis_tlast_in ? HDR : DRAIN;
                        end else if (axis_tlast_in) begin
                            // Valid header but no payload words behind it.
                            drop_d  = 1'b1;
                            code_d  = 3'd7;
                            state_d = HDR;
                        end else begin
                            proto_d = hproto_q;
                            src_d   = hsrc_q;
                            plen_d  = plen_s[15:0];
                            rem_d   = plen_s[15:0];
                            state_d = PAYLOAD;
                        end
                    end else if (axis_tlast_in) begin
                        wcnt_d  = 4'd0;
                        drop_d  = 1'b1;
                        code_d  = 3'd7;
                        state_d = HDR;
                    end else if (wcnt_q == 4'd4) begin
                        state_d = OPT;
                    end
                end
            end
            PAYLOAD: begin
                if (beat) begin
                    data_d  = axis_tdata_in;
                    valid_d = 1'b1;
                    keep_d  = axis_tkeep_in & keep_mask;
                    last_d  = (rem_q <= 16'd4) || axis_tlast_in;
                    if (rem_q <= 16'd4) begin
                        rem_d   = 16'd0;
                        state_d = axis_tlast_in ? HDR : DRAIN;
                    end else begin
                        rem_d = rem_q - 16'd4;
                        if (axis_tlast_in) begin
                            short_d = 1'b1;
                            state_d = HDR;
                        end
                    end
                end
            end
            DRAIN: begin
                if (beat && axis_tlast_in) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HDR;    wcnt_q   <= '0; csum_q  <= '0;
            ver_q    <= '0;     ihl_q    <= '0; tl_q    <= '0;
            frag_q   <= 1'b0;   hproto_q <= '0; hsrc_q  <= '0;
            dst_q    <= '0;     rem_q    <= '0; data_q  <= '0;
            valid_q  <= 1'b0;   keep_q   <= '0; last_q  <= 1'b0;
            proto_q  <= '0;     src_q    <= '0; plen_q  <= '0;
            code_q   <= '0;     drop_q   <= 1'b0; short_q <= 1'b0;
        end else begin
            state_q  <= state_d;  wcnt_q   <= wcnt_d;   csum_q  <= csum_d;
            ver_q    <= ver_d;    ihl_q    <= ihl_d;    tl_q    <= tl_d;
            frag_q   <= frag_d;   hproto_q <= hproto_d; hsrc_q  <= hsrc_d;
            dst_q    <= dst_d;    rem_q    <= rem_d;    data_q  <= data_d;
            valid_q  <= valid_d;  keep_q   <= keep_d;   last_q  <= last_d;
            proto_q  <= proto_d;  src_q    <= src_d;    plen_q  <= plen_d;
            code_q   <= code_d;   drop_q   <= drop_d;   short_q <= short_d;
        end
    end

    assign data_out           = data_q;
    assign data_valid_out     = valid_q;
    assign data_keep_out      = keep_q;
    assign data_last_out      = last_q;
    assign proto_out          = proto_q;
    assign src_ip_out         = src_q;
    assign payload_length_out = plen_q;
    assign drop_out           = drop_q;
    assign drop_code_out      = code_q;
    assign short_err_out      = short_q;
endmodule

// File: tb/tb_ip_recv.sv
// Bench for ip_recv: directed and random IPv4 packets compared against a
// byte-level reference model of the receive rules.
module tb_ip_recv;
    localparam logic [31:0] LOCAL_IP = 32'hC0A8_010A;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] local_IP_in;
    logic [31:0] axis_tdata_in;
    logic        axis_tvalid_in;
    logic [3:0]  axis_tkeep_in;
    logic        axis_tlast_in;
    logic        axis_tready_out;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic [3:0]  data_keep_out;
    logic        data_last_out;
    logic        data_ready_in = 1'b1;
    logic [7:0]  proto_out;
    logic [31:0] src_ip_out;
    logic [15:0] payload_length_out;
    logic        drop_out;
    logic [2:0]  drop_code_out;
    logic        short_err_out;

    always #5 clk = ~clk;

    ip_recv #(.BCAST_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .local_IP_in(local_IP_in),
        .axis_tdata_in(axis_tdata_in), .axis_tvalid_in(axis_tvalid_in),
        .axis_tkeep_in(axis_tkeep_in), .axis_tlast_in(axis_tlast_in),
        .axis_tready_out(axis_tready_out), .data_out(data_out),
        .data_valid_out(data_valid_out), .data_keep_out(data_keep_out),
        .data_last_out(data_last_out), .data_ready_in(data_ready_in),
        .proto_out(proto_out), .src_ip_out(src_ip_out),
        .payload_length_out(payload_length_out), .drop_out(drop_out),
        .drop_code_out(drop_code_out), .short_err_out(short_err_out)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [36:0] exp_q[$], obs_q[$];
    logic [2:0]  exp_drop_q[$], obs_drop_q[$];
    int exp_short = 0, obs_short = 0;
    int hold_err = 0, stall_err = 0, tready_err = 0;
    int tr_lo = -1, tr_hi = -1;
    int rdy_mode = 0;
    logic [7:0]  pb[$];
    logic [7:0]  exp_proto = '0;
    logic [31:0] exp_src = '0;
    logic [15:0] exp_plen = '0;

    // ---------------- clock-side processes: ready pattern and output monitor
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       data_ready_in = 1'b1;
            1:       data_ready_in = ~data_ready_in;
            default: data_ready_in = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic        prev_stall = 1'b0;
    logic [36:0] prev_w = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && (!data_valid_out || {data_out, data_keep_out, data_last_out} != prev_w))
                hold_err++;
            if (data_valid_out && data_ready_in) obs_q.push_back({data_out, data_keep_out, data_last_out});
            if (drop_out) obs_drop_q.push_back(drop_code_out);
            if (short_err_out) obs_short++;
        end
        prev_stall = data_valid_out && !data_ready_in && !reset;
        prev_w = {data_out, data_keep_out, data_last_out};
    end

    // ---------------- helpers
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] byte_at(input int i);
        return (i < pb.size()) ? pb[i] : 8'h00;
    endfunction

    function automatic logic [35:0] word_at(input int w);
        logic [31:0] d;
        logic [3:0]  k;
        d = '0;
        k = '0;
        for (int b = 0; b < 4; b++)
            if (4 * w + b < pb.size()) begin
                d[31 - 8 * b -: 8] = pb[4 * w + b];
                k[3 - b] = 1'b1;
            end
        return {d, k};
    endfunction

    function automatic logic [3:0] cnt_keep(input int cnt);
        logic [7:0] t;
        t = 8'h0F << (4 - cnt);
        return t[3:0];
    endfunction

    task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                         input logic [15:0] tl, input logic [31:0] dst, input logic [15:0] ff,
                         input int nb, input bit bad_ck);
        int hb;
        logic [31:0] s;
        hb = ((ihl > 4'd5) ? int'(ihl) : 5) * 4;
        pb.delete();
        for (int i = 0; i < ((nb > hb) ? nb : hb); i++) pb.push_back(8'($urandom));
        pb[0] = {ver, ihl};   pb[1] = 8'h00;
        pb[2] = tl[15:8];     pb[3] = tl[7:0];
        pb[6] = ff[15:8];     pb[7] = ff[7:0];
        pb[8] = 8'd64;        pb[9] = proto;
        pb[10] = 8'h00;       pb[11] = 8'h00;
        pb[16] = dst[31:24];  pb[17] = dst[23:16];
        pb[18] = dst[15:8];   pb[19] = dst[7:0];
        s = 0;
        for (int i = 0; i < hb; i += 2) s += {16'd0, pb[i], pb[i + 1]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        pb[10] = ~s[15:8];
        pb[11] = ~s[7:0] ^ {7'd0, bad_ck};
        while (pb.size() > nb) void'(pb.pop_back());
    endtask

    // Reference model: what the receive rules say should come out of pb.
    task automatic model();
        int nb, nw, ihl, hlen, plen, avail, nout, nwp, cnt;
        logic [31:0] s, dst;
        logic [15:0] fo;
        logic [2:0]  code;
        logic [35:0] wk;
        tr_lo = -1;
        tr_hi = -1;
        nb = pb.size();
        nw = (nb + 3) / 4;
        if (nw < 5) begin exp_drop_q.push_back(3'd7); return; end
        ihl  = int'(byte_at(0) & 8'h0F);
        hlen = (ihl > 5) ? ihl : 5;
        if (nw < hlen) begin exp_drop_q.push_back(3'd7); return; end
        s = 0;
        for (int i = 0; i < hlen * 4; i += 2) s += {16'd0, byte_at(i), byte_at(i + 1)};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        plen = int'({byte_at(2), byte_at(3)}) - 4 * ihl;
        dst  = {byte_at(16), byte_at(17), byte_at(18), byte_at(19)};
        fo   = {byte_at(6), byte_at(7)};
        code = 3'd0;
        if (byte_at(0) >> 4 != 8'd4 || ihl < 5)              code = 3'd1;
        else if (s[15:0] != 16'hFFFF)                        code = 3'd2;
        else if (dst != LOCAL_IP && dst != 32'hFFFF_FFFF)    code = 3'd3;
        else if ((fo & 16'h3FFF) != 16'd0)                   code = 3'd4;
        else if (byte_at(9) != 8'd6 && byte_at(9) != 8'd17)  code = 3'd5;
        else if (plen <= 0)                                  code = 3'd6;
        else if (nw == hlen)                                 code = 3'd7;
        if (code != 3'd0) begin exp_drop_q.push_back(code); return; end
        exp_proto = byte_at(9);
        exp_src   = {byte_at(12), byte_at(13), byte_at(14), byte_at(15)};
        exp_plen  = 16'(plen);
        avail = nb - 4 * hlen;
        nwp   = nw - hlen;
        nout  = (plen < avail) ? plen : avail;
        if (plen > 4 * nwp) exp_short++;
        for (int i = 0; i < (nout + 3) / 4; i++) begin
            cnt = nout - 4 * i;
            if (cnt > 4) cnt = 4;
            wk = word_at(hlen + i);
            exp_q.push_back({wk[35:4], cnt_keep(cnt), (i == (nout + 3) / 4 - 1)});
        end
        tr_lo = hlen;
        tr_hi = hlen + (plen + 3) / 4 - 1;
    endtask

    // Drive words of pb; stops early (without tlast) when limit is reached.
    task automatic send_words(input int limit);
        int nw, stop, cyc;
        bit acc;
        logic [35:0] wk;
        nw = (pb.size() + 3) / 4;
        stop = (limit < nw) ? limit : nw;
        for (int w = 0; w < stop; w++) begin
            wk = word_at(w);
            axis_tdata_in  = wk[35:4];
            axis_tkeep_in  = wk[3:0];
            axis_tlast_in  = (w == nw - 1);
            axis_tvalid_in = 1'b1;
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc <= 200) begin
                @(negedge clk);
                acc = axis_tready_out;
                if (w >= tr_lo && w <= tr_hi && axis_tready_out !== (!data_valid_out || data_ready_in))
                    tready_err++;
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) stall_err++;
        end
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
    endtask

    task automatic run_pkt();
        model();
        send_words(1000);
    endtask

    task automatic settle();
        int cyc;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        while ((obs_q.size() < exp_q.size() || data_valid_out) && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        exp_q.delete(); obs_q.delete();
        exp_drop_q.delete(); obs_drop_q.delete();
        exp_short = 0; obs_short = 0;
    endtask

    task automatic compare(input string tag);
        check($sformatf("%s nwords", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < obs_q.size()) check($sformatf("%s word%0d", tag, i), obs_q[i], exp_q[i]);
        check($sformatf("%s ndrops", tag), obs_drop_q.size(), exp_drop_q.size());
        for (int i = 0; i < exp_drop_q.size(); i++)
            if (i < obs_drop_q.size()) check($sformatf("%s drop_code%0d", tag, i), obs_drop_q[i], exp_drop_q[i]);
        check($sformatf("%s short_err", tag), obs_short, exp_short);
        check($sformatf("%s meta", tag), {proto_out, src_ip_out, payload_length_out},
              {exp_proto, exp_src, exp_plen});
        check($sformatf("%s protocol", tag), {hold_err[15:0], stall_err[15:0], tready_err[15:0]}, 48'd0);
        clear_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " outputs"}, {data_out, data_valid_out, data_keep_out, data_last_out,
                                  drop_out, drop_code_out, short_err_out}, 64'd0);
        check({tag, " meta"}, {proto_out, src_ip_out, payload_length_out}, 64'd0);
        check({tag, " tready"}, axis_tready_out, 1'b1);
    endtask

    // ---------------- directed sequence, then random traffic
    initial begin
        int r, ihl, plen, tl, nb;
        logic [15:0] ff;
        logic [31:0] dst;
        reset = 1'b1;
        local_IP_in = LOCAL_IP;
        axis_tdata_in = '0;
        axis_tvalid_in = 1'b0;
        axis_tkeep_in = '0;
        axis_tlast_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        build(4'd4, 4'd5, 8'd17, 16'd40, LOCAL_IP, 16'h0000, 40, 1'b0);
        run_pkt(); settle(); compare("udp40");

        build(4'd4, 4'd5, 8'd17, 16'd40, LOCAL_IP, 16'h4000, 46, 1'b0);
        run_pkt();
        build(4'd4, 4'd5, 8'd6, 16'd33, LOCAL_IP, 16'h0000, 33, 1'b0);
        run_pkt(); settle(); compare("padded+next");

        build(4'd4, 4'd5, 8'd17, 16'd40, LOCAL_IP, 16'h0000, 40, 1'b1);
        run_pkt(); settle(); compare("bad_csum");

        build(4'd4, 4'd6, 8'd6, 16'd31, LOCAL_IP, 16'h0000, 31, 1'b0);
        run_pkt(); settle(); compare("ihl6_tcp7");

        rdy_mode = 1;
        build(4'd4, 4'd5, 8'd17, 16'd60, 32'hFFFF_FFFF, 16'h0000, 60, 1'b0);
        run_pkt(); settle(); compare("toggle_ready");

        build(4'd4, 4'd5, 8'd17, 16'd60, LOCAL_IP, 16'h0000, 60, 1'b0);
        tr_lo = -1;
        tr_hi = -1;
        send_words(8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        clear_all();
        exp_proto = '0; exp_src = '0; exp_plen = '0;
        build(4'd4, 4'd5, 8'd6, 16'd36, LOCAL_IP, 16'h0000, 36, 1'b0);
        run_pkt(); settle(); compare("after_reset");
        rdy_mode = 0;

        build(4'd4, 4'd5, 8'd17, 16'd40, LOCAL_IP, 16'h0000, 28, 1'b0);
        run_pkt(); settle(); compare("early_tlast");
        build(4'd4, 4'd5, 8'd17, 16'd40, LOCAL_IP, 16'h0000, 12, 1'b0);
        run_pkt(); settle(); compare("hdr_tlast");
        build(4'd6, 4'd5, 8'd17, 16'd40, LOCAL_IP, 16'h0000, 40, 1'b0);
        run_pkt();
        build(4'd4, 4'd5, 8'd17, 16'd40, 32'h0A00_0001, 16'h0000, 40, 1'b0);
        run_pkt();
        build(4'd4, 4'd5, 8'd17, 16'd40, LOCAL_IP, 16'h2000, 40, 1'b0);
        run_pkt();
        build(4'd4, 4'd5, 8'd1, 16'd40, LOCAL_IP, 16'h0000, 40, 1'b0);
        run_pkt();
        build(4'd4, 4'd5, 8'd17, 16'd20, LOCAL_IP, 16'h0000, 24, 1'b0);
        run_pkt(); settle(); compare("drop_codes");

        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            r    = $urandom_range(0, 11);
            ihl  = $urandom_range(5, 7);
            plen = $urandom_range(1, 40);
            tl   = 4 * ihl + plen;
            dst  = (r == 2) ? $urandom : ((r == 3) ? 32'hFFFF_FFFF : LOCAL_IP);
            ff   = (r == 4) ? 16'h2000 : ((r == 5) ? 16'h0003 : ($urandom_range(0, 1) ? 16'h4000 : 16'h0000));
            nb   = (r == 6) ? tl - $urandom_range(1, plen) : tl + ($urandom_range(0, 1) ? $urandom_range(0, 12) : 0);
            build((r == 0) ? 4'd6 : 4'd4, 4'(ihl), (r == 1) ? 8'd1 : ($urandom_range(0, 1) ? 8'd6 : 8'd17),
                  16'(tl), dst, ff, nb, r == 7);
            run_pkt();
            if (p % 4 == 3) begin
                settle();
                compare($sformatf("rand%0d", p));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
